// File: rtl/mm_pkg.sv
// Shared matrix-multiply definitions: default array geometry, result element type and
// the output deskew FSM state encoding.
package mm_pkg;

  localparam int DEF_DIM    = 8;
  localparam int DEF_BITS_C = 24;

  typedef logic signed [DEF_BITS_C-1:0] c_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } deskew_state_t;

endpackage

// File: rtl/memc_deskew.sv
// Re-aligns the diagonally skewed result wavefront of the systolic array into a DIM x DIM
// buffer, then drains it one aligned row per valid/ready handshake.
module memc_deskew
  import mm_pkg::*;
#(
  parameter int DIM    = DEF_DIM,
  parameter int BITS_C = DEF_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      start,
  input  logic [DIM*BITS_C-1:0]     Cin,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIM*BITS_C-1:0]     out_data,
  output logic [$clog2(DIM)-1:0]    out_row,
  output logic                      err_ovr
);

  localparam int SW = $clog2(2*DIM);
  localparam int RW = $clog2(DIM);
  localparam logic [SW-1:0] LAST_STEP = SW'(2*DIM-2);
  localparam logic [RW-1:0] LAST_ROW  = RW'(DIM-1);

  deskew_state_t state, state_next;
  logic [SW-1:0] step, step_next;
  logic          busy_next;
  logic          valid_next;
  logic [RW-1:0] row_next;
  logic          load_row;
  logic          cap;

  logic signed [BITS_C-1:0] buffer [DIM][DIM];
  logic [DIM*BITS_C-1:0]    row_vec [DIM];

  // Buffer cell (r,j) is written when the wavefront step reaches r+j; in IDLE step is 0,
  // so an accepted start captures cell (0,0) through the same decode.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      localparam logic [SW-1:0] RJ = SW'(r + j);

      always_ff @(posedge clk) begin
        if (rst) begin
          buffer[r][j] <= '0;
        end else if (cap && (step == RJ)) begin
          buffer[r][j] <= Cin[j*BITS_C +: BITS_C];
        end else begin
          buffer[r][j] <= buffer[r][j];
        end
      end

      assign row_vec[r][j*BITS_C +: BITS_C] = buffer[r][j];
    end
  end

  // Next-state and next-output decode for the collect/drain sequence
  always_comb begin
    state_next = state;
    step_next  = step;
    busy_next  = busy;
    valid_next = out_valid;
    row_next   = out_row;
    load_row   = 1'b0;
    cap        = 1'b0;
    case (state)
      IDLE: begin
        if (en && start) begin
          cap        = 1'b1;
          step_next  = SW'(1);
          busy_next  = 1'b1;
          state_next = COLLECT;
        end else begin
          state_next = IDLE;
        end
      end
      COLLECT: begin
        if (en) begin
          cap = 1'b1;
          if (step == LAST_STEP) begin
            // Row 0 completed at step DIM-1, so it can be loaded on this same edge.
            step_next  = '0;
            valid_next = 1'b1;
            row_next   = '0;
            load_row   = 1'b1;
            state_next = DRAIN;
          end else begin
            step_next = step + SW'(1);
          end
        end else begin
          state_next = COLLECT;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (out_row == LAST_ROW) begin
            valid_next = 1'b0;
            busy_next  = 1'b0;
            row_next   = '0;
            state_next = IDLE;
          end else begin
            row_next = out_row + RW'(1);
            load_row = 1'b1;
          end
        end else begin
          state_next = DRAIN;
        end
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
        busy_next  = 1'b0;
        valid_next = 1'b0;
        row_next   = '0;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
      err_ovr   <= 1'b0;
    end else begin
      state     <= state_next;
      step      <= step_next;
      busy      <= busy_next;
      out_valid <= valid_next;
      out_row   <= row_next;
      if (load_row) begin
        out_data <= row_vec[row_next];
      end else begin
        out_data <= out_data;
      end
      if (en && start && busy) begin
        err_ovr <= 1'b1;
      end else begin
        err_ovr <= err_ovr;
      end
    end
  end

endmodule
